// File: rtl/half_adder_pkg.sv
// Shared types and constants for the registered ripple-carry half adder.
// Widths of the combinational result are sized to the largest legal WIDTH.

package half_adder_pkg;

   localparam int unsigned HA_MAX_WIDTH = 64;

   typedef struct packed {
      logic                    c_out;
      logic [HA_MAX_WIDTH-1:0] sum;
   } ha_result_t;

   // Even-parity bit of a zero-extended sum; upper zero bits do not change it.
   function automatic logic ha_parity(input logic [HA_MAX_WIDTH-1:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purely combinational 1-bit half adder: s = x ^ y, c = x & y.

module half_adder_cell (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-bit unsigned adder (no carry-in) built as a ripple chain of half_adder_cell.
// Define HALF_ADDER_PARITY_EN to add a registered even-parity output sum_par.

module half_adder
   import half_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             out_valid
`ifdef HALF_ADDER_PARITY_EN
   ,
   output logic             sum_par
`endif
);

   logic [WIDTH-1:0] s_bit;
   logic             carry_msb;
   ha_result_t       res;

   // Each stage keeps its own carry so the chain has no self-loop through one vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic c_o;
      if (i == 0) begin : g_ha
         half_adder_cell u_cell (
            .x (a[i]),
            .y (b[i]),
            .s (s_bit[i]),
            .c (c_o)
         );
      end else begin : g_fa
         logic c_in;
         logic p;
         logic g;
         logic t;
         assign c_in = g_bit[i-1].c_o;
         half_adder_cell u_hi (
            .x (a[i]),
            .y (b[i]),
            .s (p),
            .c (g)
         );
         half_adder_cell u_lo (
            .x (p),
            .y (c_in),
            .s (s_bit[i]),
            .c (t)
         );
         assign c_o = g | t;
      end
   end

   assign carry_msb = g_bit[WIDTH-1].c_o;

   always_comb begin
      res                  = '0;
      res.sum[WIDTH-1:0]   = s_bit;
      res.c_out            = carry_msb;
   end

   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            sum_q   <= res.sum[WIDTH-1:0];
            c_out_q <= res.c_out;
         end
      end
   end

   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign out_valid = out_valid_q;

`ifdef HALF_ADDER_PARITY_EN
   logic sum_par_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_par_q <= 1'b0;
      end else if (in_valid) begin
         sum_par_q <= ha_parity(res.sum);
      end
   end

   assign sum_par = sum_par_q;
`else
   // Upper struct bits are zero by construction; keep them visibly consumed.
   logic unused_res_hi;
   assign unused_res_hi = ha_parity(res.sum);
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a WIDTH=1 and a WIDTH=8 instance driven side by side.
// Parity output is checked when HALF_ADDER_PARITY_EN is defined.

module tb_half_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, a1, b1, v1;
   logic       sum1, c1, ov1;
   logic       rst8, v8;
   logic [7:0] a8, b8;
   logic [7:0] sum8;
   logic       c8, ov8;
`ifdef HALF_ADDER_PARITY_EN
   logic       par1, par8;
`endif

   int total = 0;
   int bad   = 0;

   half_adder #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst1),
      .a         (a1),
      .b         (b1),
      .in_valid  (v1),
      .sum       (sum1),
      .c_out     (c1),
      .out_valid (ov1)
`ifdef HALF_ADDER_PARITY_EN
      ,
      .sum_par   (par1)
`endif
   );

   half_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst8),
      .a         (a8),
      .b         (b8),
      .in_valid  (v8),
      .sum       (sum8),
      .c_out     (c8),
      .out_valid (ov8)
`ifdef HALF_ADDER_PARITY_EN
      ,
      .sum_par   (par8)
`endif
   );

   typedef struct packed {
      logic       valid;
      logic       c;
      logic [7:0] sum;
      logic       par;
   } exp_t;

   exp_t q1[$];
   exp_t q8[$];

   // Reference state: what each DUT's registers should hold.
   logic       m1_sum, m1_c;
   logic [7:0] m8_sum;
   logic       m8_c;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r_1, input logic v_1, input logic a_1, input logic b_1,
                        input logic r_8, input logic v_8, input logic [7:0] a_8,
                        input logic [7:0] b_8);
      exp_t e1;
      exp_t e8;
      rst1 = r_1; v1 = v_1; a1 = a_1; b1 = b_1;
      rst8 = r_8; v8 = v_8; a8 = a_8; b8 = b_8;
      e1.valid = 1'b0;
      if (r_1) begin
         m1_sum = 1'b0;
         m1_c   = 1'b0;
      end else if (v_1) begin
         {m1_c, m1_sum} = {1'b0, a_1} + {1'b0, b_1};
         e1.valid = 1'b1;
      end
      e1.c   = m1_c;
      e1.sum = {7'b0, m1_sum};
      e1.par = m1_sum;
      q1.push_back(e1);
      e8.valid = 1'b0;
      if (r_8) begin
         m8_sum = 8'h00;
         m8_c   = 1'b0;
      end else if (v_8) begin
         {m8_c, m8_sum} = {1'b0, a_8} + {1'b0, b_8};
         e8.valid = 1'b1;
      end
      e8.c   = m8_c;
      e8.sum = m8_sum;
      e8.par = ^m8_sum;
      q8.push_back(e8);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("w1_valid", 64'(ov1), 64'(e.valid));
         check("w1_sum", 64'(sum1), 64'(e.sum[0]));
         check("w1_cout", 64'(c1), 64'(e.c));
`ifdef HALF_ADDER_PARITY_EN
         check("w1_par", 64'(par1), 64'(e.par));
`endif
      end
      if (q8.size() > 0) begin
         e = q8.pop_front();
         check("w8_valid", 64'(ov8), 64'(e.valid));
         check("w8_sum", 64'(sum8), 64'(e.sum));
         check("w8_cout", 64'(c8), 64'(e.c));
`ifdef HALF_ADDER_PARITY_EN
         check("w8_par", 64'(par8), 64'(e.par));
`endif
      end
   end

   initial begin
      logic xb;
      logic [7:0] xv;
      xb = 1'bx;
      xv = 8'hxx;
      m1_sum = 1'b0; m1_c = 1'b0; m8_sum = 8'h00; m8_c = 1'b0;

      // Reset for two cycles, then idle
      drive(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      drive(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check("reset_w8", 64'({ov8, c8, sum8}), 64'(10'h000));

      // 1-bit truth table alongside 8-bit wrap / maximum / 3C latch
      drive(0, 1, 0, 0, 0, 1, 8'hFF, 8'h01);
      check("tp3_wrap", 64'({c8, sum8}), 64'(9'h100));
      drive(0, 1, 1, 0, 0, 1, 8'hFF, 8'hFF);
      check("tp3_max", 64'({c8, sum8}), 64'(9'h1FE));
      check("tp2_10", 64'({c1, sum1}), 64'(2'b01));
      drive(0, 1, 1, 1, 0, 1, 8'h1E, 8'h1E);
      check("tp2_11", 64'({c1, sum1}), 64'(2'b10));
      drive(0, 1, 0, 1, 0, 0, 8'h11, 8'h22);
      check("tp4_hold", 64'({ov8, sum8}), 64'(9'h03C));
      // X operands while idle must not disturb held outputs
      drive(0, 0, xb, xb, 0, 0, xv, xv);

      // Reset overrides in_valid on the same edge, then first result
      drive(0, 0, 0, 0, 1, 1, 8'h80, 8'h80);
      check("tp5_rst", 64'({ov8, c8, sum8}), 64'(10'h000));
      drive(0, 0, 0, 0, 0, 1, 8'h80, 8'h80);
      check("tp5_after", 64'({ov8, c8, sum8}), 64'(10'h300));

      // Parity patterns (parity itself checked only when the port exists)
      drive(0, 0, 0, 0, 0, 1, 8'h03, 8'h04);
      drive(0, 0, 0, 0, 0, 1, 8'h01, 8'h02);
      drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

      for (int i = 0; i < 60; i++) begin
         logic r;
         r = ($urandom_range(0, 15) == 0);
         drive(r, 1'($urandom), 1'($urandom), 1'($urandom),
               r, 1'($urandom), 8'($urandom), 8'($urandom));
      end

      @(posedge clk);
      #2;
      check("drain", 64'(q1.size() + q8.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
